muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers, the parametrised multi-cycle successor to the single-shot multiply/divide paths of the integer ALU. It accepts one request at a time over a valid/ready handshake and computes one result bit per cycle. It supports signed and unsigned MUL, DIV, MADD and MSUB, with cancel and divide-by-zero reporting. It sits beside the ALU in the execute stage; the pipeline stalls on `req_ready` low and reads `hi`/`lo` directly.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Produces one product or quotient bit per cycle. Results are written back in a single FIX cycle.
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             resp_valid,
  output logic             div_by_zero
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MADD = 2'b10;
  localparam logic [1:0] OP_MSUB = 2'b11;
  localparam int         CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_e               state_q, state_d;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic                 a_neg_q;
  logic                 dbz_q;
  logic [WIDTH-1:0]     b_mag_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 resp_valid_q, div_by_zero_q;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    a_neg, b_neg, accept, req_dbz, fix_done;
  logic [WIDTH-1:0]        a_mag, b_mag;

  assign a_s     = signed'(data_a);
  assign b_s     = signed'(data_b);
  assign a_neg   = sign && (a_s < 0);
  assign b_neg   = sign && (b_s < 0);
  assign a_mag   = cond_neg_w(data_a, a_neg);
  assign b_mag   = cond_neg_w(data_b, b_neg);
  assign accept  = req_valid && (state_q == S_IDLE);
  assign req_dbz = (op == OP_DIV) && (data_b == '0);
  assign fix_done = (state_q == S_FIX) && !cancel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = req_dbz ? S_FIX : S_RUN;
      S_RUN: begin
        if (cancel)                 state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // p_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_mag_q : '0)};
  assign mul_next = {mul_sum, p_q[WIDTH-1:1]};
  assign rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_mag_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op;
      neg_q   <= a_neg ^ b_neg;
      a_neg_q <= a_neg;
      dbz_q   <= req_dbz;
      b_mag_q <= b_mag;
      cnt_q   <= '0;
      p_q     <= req_dbz ? {data_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      p_q   <= (op_q == OP_DIV) ? div_next : mul_next;
    end
  end

  logic [2*WIDTH-1:0] prod_s, acc, result;

  assign prod_s = cond_neg_2w(p_q, neg_q);
  assign acc    = {hi_q, lo_q};

  always_comb begin
    result = prod_s;
    if (dbz_q) begin
      result = p_q;
    end else begin
      case (op_q)
        OP_DIV:  result = {cond_neg_w(p_q[2*WIDTH-1:WIDTH], a_neg_q),
                           cond_neg_w(p_q[WIDTH-1:0], neg_q)};
        OP_MADD: if (ACC_EN) result = acc + prod_s;
        OP_MSUB: if (ACC_EN) result = acc - prod_s;
        default: result = prod_s;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      resp_valid_q  <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_valid_q  <= fix_done;
      div_by_zero_q <= fix_done && dbz_q;
      if (fix_done) {hi_q, lo_q} <= result;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign resp_valid  = resp_valid_q;
  assign div_by_zero = div_by_zero_q;

endmodule
